playback_transport_ctrl: RTL and testbench

- Parametrised transport controller for the music player: STOP / PLAY / PAUSE state machine plus a beat-position counter.
- Driven by one-pulse button strobes and a beat tick from the tempo divider.
- Beat index addresses the song ROM; `play_or_pause` gates the tone generator.
- Adds stop, loop mode, skip forward/back and end-of-song handling beyond a plain play/pause toggle.

---
 rtl/player_pkg.sv | 24 ++
 rtl/beat_counter.sv | 52 +++++
 rtl/playback_transport_ctrl.sv | 101 ++++++++++
 tb/tb_playback_transport_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared player definitions: transport states, beat-counter ops and default sizes.
// The song ROM and the tempo divider use the same default sizes.
package player_pkg;

  localparam int unsigned StateW   = 2;
  localparam int unsigned DefAddrW = 9;
  localparam int unsigned DefSkip  = 16;

  typedef enum logic [StateW-1:0] {
    StStop  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2
  } state_e;

  // One-hot beat-counter command. All zeros means hold.
  typedef enum logic [3:0] {
    OpHold = 4'b0000,
    OpZero = 4'b0001,
    OpInc  = 4'b0010,
    OpFwd  = 4'b0100,
    OpRev  = 4'b1000
  } beat_op_e;

endpackage

// File: rtl/beat_counter.sv
// Beat-position register: load-zero, increment and saturating skip.
// It reports whether the index is on the last beat or past the end of the song.
module beat_counter
  import player_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned SKIP   = DefSkip
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  beat_op_e          op_i,
  input  logic [ADDR_W-1:0] song_len_i,
  output logic [ADDR_W-1:0] beat_idx_o,
  output logic              last_o,
  output logic              over_o
);

  localparam logic [ADDR_W:0] SkipW = (ADDR_W+1)'(SKIP);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_eff, max_idx;
  logic [ADDR_W:0]   fwd_sum;

  // A zero length is treated as a one-beat song.
  assign len_eff = (song_len_i == '0) ? ADDR_W'(1) : song_len_i;
  assign max_idx = len_eff - ADDR_W'(1);
  assign fwd_sum = {1'b0, idx_q} + SkipW;

  assign last_o     = (idx_q == max_idx);
  assign over_o     = (idx_q >= len_eff);
  assign beat_idx_o = idx_q;

  always_comb begin
    idx_d = idx_q;
    unique case (op_i)
      OpZero:  idx_d = '0;
      OpInc:   idx_d = idx_q + ADDR_W'(1);
      OpFwd:   idx_d = (fwd_sum > {1'b0, max_idx}) ? max_idx : fwd_sum[ADDR_W-1:0];
      OpRev:   idx_d = ({1'b0, idx_q} < SkipW) ? '0 : idx_q - SkipW[ADDR_W-1:0];
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/playback_transport_ctrl.sv
// STOP/PLAY/PAUSE transport FSM with loop mode and end-of-song pulse.
// The beat position is held in beat_counter; all outputs are registered.
module playback_transport_ctrl
  import player_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned SKIP     = DefSkip,
  parameter bit          LOOP_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_1p,
  input  logic              stop_1p,
  input  logic              loop_1p,
  input  logic              fwd_1p,
  input  logic              rev_1p,
  input  logic              beat_tick,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] beat_idx,
  output logic              play_or_pause,
  output logic [StateW-1:0] state,
  output logic              loop_en,
  output logic              song_done
);

  state_e   state_q, state_d;
  logic     pop_q;
  logic     loop_q, loop_d;
  logic     done_q, done_d;
  beat_op_e op;
  logic     last, over, legal;

  beat_counter #(
    .ADDR_W (ADDR_W),
    .SKIP   (SKIP)
  ) u_beat_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .op_i       (op),
    .song_len_i (song_len),
    .beat_idx_o (beat_idx),
    .last_o     (last),
    .over_o     (over)
  );

  assign legal = state_q inside {StStop, StPlay, StPause};

  // Priority chain: at most one action fires per cycle; loop toggling sits outside it.
  always_comb begin
    state_d = state_q;
    op      = OpHold;
    done_d  = 1'b0;
    loop_d  = loop_q ^ loop_1p;
    if (stop_1p || !legal) begin
      state_d = StStop;
      op      = OpZero;
    end else if (state_q != StStop && over) begin
      op = OpZero;
    end else if (play_1p) begin
      unique case (state_q)
        StStop: begin
          state_d = StPlay;
          op      = OpZero;
        end
        StPlay:  state_d = StPause;
        StPause: state_d = StPlay;
        default: state_d = StStop;
      endcase
    end else if ((fwd_1p ^ rev_1p) && state_q != StStop) begin
      op = fwd_1p ? OpFwd : OpRev;
    end else if (beat_tick && state_q == StPlay) begin
      if (last) begin
        op     = OpZero;
        done_d = 1'b1;
        if (!loop_q) state_d = StStop;
      end else begin
        op = OpInc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStop;
      pop_q   <= 1'b0;
      loop_q  <= LOOP_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= (state_d == StPlay);
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  assign state         = state_q;
  assign play_or_pause = pop_q;
  assign loop_en       = loop_q;
  assign song_done     = done_q;

endmodule

// File: tb/tb_playback_transport_ctrl.sv
// Directed bench for playback_transport_ctrl with hand-computed expected vectors.
module tb_playback_transport_ctrl;

  localparam int unsigned AW = 9;
  // Button bundle order: {play, stop, loop, fwd, rev, tick}
  localparam logic [5:0] BNone = 6'b000000;
  localparam logic [5:0] BPlay = 6'b100000;
  localparam logic [5:0] BStop = 6'b010000;
  localparam logic [5:0] BLoop = 6'b001000;
  localparam logic [5:0] BFwd  = 6'b000100;
  localparam logic [5:0] BRev  = 6'b000010;
  localparam logic [5:0] BTick = 6'b000001;

  logic          clk = 1'b0;
  logic          rst;
  logic          play_1p, stop_1p, loop_1p, fwd_1p, rev_1p, beat_tick;
  logic [AW-1:0] song_len;
  logic [AW-1:0] beat_idx;
  logic          play_or_pause;
  logic [1:0]    state;
  logic          loop_en;
  logic          song_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Observed vector: {state, beat_idx, play_or_pause, loop_en, song_done}
  logic [13:0] obs;
  logic [13:0] exp_v;
  assign obs = {state, beat_idx, play_or_pause, loop_en, song_done};

  playback_transport_ctrl #(
    .ADDR_W   (AW),
    .SKIP     (16),
    .LOOP_RST (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play_1p       (play_1p),
    .stop_1p       (stop_1p),
    .loop_1p       (loop_1p),
    .fwd_1p        (fwd_1p),
    .rev_1p        (rev_1p),
    .beat_tick     (beat_tick),
    .song_len      (song_len),
    .beat_idx      (beat_idx),
    .play_or_pause (play_or_pause),
    .state         (state),
    .loop_en       (loop_en),
    .song_done     (song_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [5:0] b);
    {play_1p, stop_1p, loop_1p, fwd_1p, rev_1p, beat_tick} = b;
    @(posedge clk);
    #1;
    {play_1p, stop_1p, loop_1p, fwd_1p, rev_1p, beat_tick} = BNone;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(BTick);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = {2'd0, 9'd0, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_play_pause();
    do_reset();
    song_len = 9'd8;
    cyc(BPlay);
    exp_v = {2'd1, 9'd0, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL play_start: got %h want %h", obs, exp_v); end
    ticks(3);
    exp_v = {2'd1, 9'd3, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL play_3ticks: got %h want %h", obs, exp_v); end
    cyc(BPlay);
    exp_v = {2'd2, 9'd3, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause: got %h want %h", obs, exp_v); end
    ticks(2);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pause_ticks: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_end_of_song();
    do_reset();
    song_len = 9'd4;
    cyc(BPlay);
    ticks(3);
    exp_v = {2'd1, 9'd3, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL eos_last: got %h want %h", obs, exp_v); end
    cyc(BTick);
    exp_v = {2'd0, 9'd0, 3'b001};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL eos_stop: got %h want %h", obs, exp_v); end
    cyc(BNone);
    exp_v = {2'd0, 9'd0, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL eos_done_1cyc: got %h want %h", obs, exp_v); end
    cyc(BLoop);
    cyc(BPlay);
    exp_v = {2'd1, 9'd0, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL loop_play: got %h want %h", obs, exp_v); end
    ticks(3);
    exp_v = {2'd1, 9'd3, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL loop_pre: got %h want %h", obs, exp_v); end
    cyc(BTick);
    exp_v = {2'd1, 9'd0, 3'b111};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL loop_wrap: got %h want %h", obs, exp_v); end
    cyc(BTick);
    exp_v = {2'd1, 9'd1, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL loop_after: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_skip();
    do_reset();
    song_len = 9'd40;
    cyc(BPlay);
    ticks(30);
    cyc(BFwd);
    exp_v = {2'd1, 9'd39, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_sat: got %h want %h", obs, exp_v); end
    cyc(BRev);
    exp_v = {2'd1, 9'd23, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rev1: got %h want %h", obs, exp_v); end
    cyc(BRev);
    exp_v = {2'd1, 9'd7, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rev2: got %h want %h", obs, exp_v); end
    cyc(BRev);
    exp_v = {2'd1, 9'd0, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rev_floor: got %h want %h", obs, exp_v); end
    cyc(BFwd);
    cyc(BFwd | BRev);
    exp_v = {2'd1, 9'd16, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_rev_both: got %h want %h", obs, exp_v); end
    cyc(BStop);
    cyc(BFwd);
    exp_v = {2'd0, 9'd0, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_in_stop: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_collisions();
    do_reset();
    song_len = 9'd8;
    cyc(BPlay);
    ticks(5);
    cyc(BPlay | BTick);
    exp_v = {2'd2, 9'd5, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL play_tick: got %h want %h", obs, exp_v); end
    cyc(BStop | BFwd | BLoop);
    exp_v = {2'd0, 9'd0, 3'b010};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stop_fwd_loop: got %h want %h", obs, exp_v); end
    cyc(BPlay);
    cyc(BFwd | BTick);
    exp_v = {2'd1, 9'd7, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_tick: got %h want %h", obs, exp_v); end
    cyc(BRev | BTick);
    exp_v = {2'd1, 9'd0, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rev_tick: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_shrink();
    do_reset();
    song_len = 9'd40;
    cyc(BPlay);
    ticks(20);
    song_len = 9'd10;
    cyc(BNone);
    exp_v = {2'd1, 9'd0, 3'b100};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL shrink: got %h want %h", obs, exp_v); end
    song_len = 9'd0;
    cyc(BTick);
    exp_v = {2'd0, 9'd0, 3'b001};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL len_zero: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    do_reset();
    song_len = 9'd16;
    cyc(BPlay);
    cyc(BLoop);
    ticks(7);
    exp_v = {2'd1, 9'd7, 3'b110};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pre_reset: got %h want %h", obs, exp_v); end
    #3;
    rst = 1'b1;
    play_1p = 1'b1;
    beat_tick = 1'b1;
    #1;
    exp_v = {2'd0, 9'd0, 3'b000};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
    play_1p = 1'b0;
    beat_tick = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    rst = 1'b1;
    song_len = 9'd8;
    {play_1p, stop_1p, loop_1p, fwd_1p, rev_1p, beat_tick} = BNone;
    test_reset();
    test_play_pause();
    test_end_of_song();
    test_skip();
    test_collisions();
    test_shrink();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
